// File: rtl/if_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, default
// end-of-program word and the bytes-per-word derivation.
package if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] HALT_DEFAULT = 32'hFFFF_FFFF;

  function automatic int bytes_per_word(input int bits);
    return bits / 8;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects bytes little-endian into a B-bit word; o_word_ready pulses
// combinationally on the cycle the final byte arrives, with o_word complete.
module byte_assembler
  import if_pkg::*;
#(
  parameter int B = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [7:0]   i_data,
  output logic         o_word_ready,
  output logic [B-1:0] o_word
);

  localparam int NB = bytes_per_word(B);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [B-1:0]  buf_q, buf_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    o_word_ready = 1'b0;
    o_word       = buf_q;
    o_word[B-1 -: 8] = i_data;
    if (i_clr) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (i_en) begin
      if (cnt_q == CW'(NB - 1)) begin
        // Counter is back at 0 next cycle, so a byte arriving then starts the next word.
        cnt_d        = '0;
        o_word_ready = 1'b1;
      end else begin
        buf_d[{cnt_q, 3'b000} +: 8] = i_data;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a byte stream into instruction memory as consecutive B-bit words,
// stopping on a HALT word or when the last slot has been written.
module instr_loader
  import if_pkg::*;
#(
  parameter int           B    = 32,
  parameter int           W    = 5,
  parameter logic [B-1:0] HALT = B'(HALT_DEFAULT)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic         o_write,
  output logic [W-1:0] o_addr,
  output logic [B-1:0] o_data,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_full,
  output logic [W:0]   o_count
);

  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W:0]   count_q, count_d;
  logic [W-1:0] addr_q, addr_d;
  logic [B-1:0] data_q, data_d;
  logic         write_q, write_d;
  logic         full_q, full_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         asm_clr;
  logic         asm_en;
  logic         word_ready;
  logic [B-1:0] word;

  byte_assembler #(.B(B)) u_asm (
    .clk          (i_clk),
    .rst_n        (i_reset),
    .i_clr        (asm_clr),
    .i_en         (asm_en),
    .i_data       (i_rx_data),
    .o_word_ready (word_ready),
    .o_word       (word)
  );

  // Bytes are only taken while loading; start in IDLE/DONE swallows a coincident byte.
  assign asm_en = (state_q == ST_LOAD) && i_rx_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = 1'b0;
    full_d  = full_q;
    asm_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          full_d  = 1'b0;
          asm_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (word_ready) begin
          write_d = 1'b1;
          data_d  = word;
          addr_d  = ptr_q;
          count_d = count_q + (W+1)'(1);
          // HALT is checked first so a HALT in the last slot is not reported as full.
          if (word == HALT) begin
            state_d = ST_DONE;
          end else if (ptr_q == '1) begin
            state_d = ST_DONE;
            full_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_write = write_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_full  = full_q;
  assign o_count = count_q;

endmodule
